// File: rtl/uart_host_bridge.sv
// Host-side initiator for the UART register interface.
// Programs config/baud, enables the core, then moves TX/RX bytes between valid/ready streams and the core FIFOs.
module uart_host_bridge #(
  parameter int TXFULL_BIT  = 1,
  parameter int RXEMPTY_BIT = 4,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [15:0] cfg_value,
  input  logic [15:0] baud_value,
  input  logic [7:0]  s_tx_data,
  input  logic        s_tx_valid,
  output logic        s_tx_ready,
  output logic [15:0] m_rx_data,
  output logic        m_rx_valid,
  input  logic        m_rx_ready,
  input  logic [15:0] uart_status,
  input  logic [15:0] uart_data_read,
  output logic [15:0] uart_config,
  output logic [15:0] uart_baudgen,
  output logic [15:0] uart_data_write,
  output logic        uart_write,
  output logic        uart_read,
  output logic        uart_en,
  output logic        configured
);

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_CFG    = 3'd1,
    ST_RUN    = 3'd2,
    ST_GAP    = 3'd3,
    ST_RDWAIT = 3'd4
  } state_t;

  localparam logic       RR_TX  = 1'b0;
  localparam logic       RR_RX  = 1'b1;
  localparam logic [1:0] LAT_TC = 2'(READ_LAT);

  state_t      state_r, state_s;
  logic        tx_ok_s, rx_ok_s, grant_tx_s, grant_rx_s;
  logic        rr_last_r, rr_last_s;
  logic [1:0]  lat_cnt_r, lat_cnt_s;
  logic [15:0] uart_config_r, uart_config_s;
  logic [15:0] uart_baudgen_r, uart_baudgen_s;
  logic [15:0] uart_data_write_r, uart_data_write_s;
  logic        uart_write_r, uart_write_s;
  logic        uart_read_r, uart_read_s;
  logic        uart_en_r, uart_en_s;
  logic        configured_r, configured_s;
  logic [15:0] m_rx_data_r, m_rx_data_s;
  logic        m_rx_valid_r, m_rx_valid_s;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_s;
    end
  end

  // Eligibility and round-robin arbitration; only meaningful in RUN without a reconfigure request
  always_comb begin
    tx_ok_s    = s_tx_valid & ~uart_status[TXFULL_BIT];
    rx_ok_s    = ~uart_status[RXEMPTY_BIT] & ~m_rx_valid_r;
    grant_tx_s = (state_r == ST_RUN) & ~cfg_start & tx_ok_s & (~rx_ok_s | (rr_last_r == RR_RX));
    grant_rx_s = (state_r == ST_RUN) & ~cfg_start & rx_ok_s & (~tx_ok_s | (rr_last_r == RR_TX));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_OFF: begin
        if (cfg_start) begin
          state_s = ST_CFG;
        end else begin
          state_s = ST_OFF;
        end
      end
      ST_CFG: state_s = ST_RUN;
      ST_RUN: begin
        if (cfg_start) begin
          state_s = ST_CFG;
        end else if (grant_tx_s) begin
          state_s = ST_GAP;
        end else if (grant_rx_s) begin
          state_s = ST_RDWAIT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_GAP: state_s = ST_RUN;
      ST_RDWAIT: begin
        if (lat_cnt_r == LAT_TC) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_RDWAIT;
        end
      end
      default: state_s = ST_OFF;
    endcase
  end

  // Next values of all registered outputs; the RX holding register is state-independent
  always_comb begin
    uart_config_s     = uart_config_r;
    uart_baudgen_s    = uart_baudgen_r;
    uart_data_write_s = uart_data_write_r;
    uart_write_s      = 1'b0;
    uart_read_s       = 1'b0;
    uart_en_s         = uart_en_r;
    rr_last_s         = rr_last_r;
    lat_cnt_s         = lat_cnt_r;
    m_rx_data_s       = m_rx_data_r;
    m_rx_valid_s      = m_rx_valid_r & ~m_rx_ready;
    case (state_r)
      ST_OFF: begin
        uart_en_s = 1'b0;
        if (cfg_start) begin
          uart_config_s  = cfg_value;
          uart_baudgen_s = baud_value;
        end else begin
          uart_config_s  = uart_config_r;
        end
      end
      ST_CFG: uart_en_s = 1'b1;
      ST_RUN: begin
        if (cfg_start) begin
          uart_en_s      = 1'b0;
          uart_config_s  = cfg_value;
          uart_baudgen_s = baud_value;
        end else if (grant_tx_s) begin
          uart_write_s      = 1'b1;
          uart_data_write_s = {8'h00, s_tx_data};
          rr_last_s         = RR_TX;
        end else if (grant_rx_s) begin
          uart_read_s = 1'b1;
          rr_last_s   = RR_RX;
          lat_cnt_s   = 2'd0;
        end else begin
          rr_last_s = rr_last_r;
        end
      end
      ST_GAP: uart_en_s = uart_en_r;
      ST_RDWAIT: begin
        if (lat_cnt_r == LAT_TC) begin
          m_rx_data_s  = uart_data_read;
          m_rx_valid_s = 1'b1;
        end else begin
          lat_cnt_s = lat_cnt_r + 2'd1;
        end
      end
      default: uart_en_s = 1'b0;
    endcase
    configured_s = (state_s == ST_RUN) | (state_s == ST_GAP) | (state_s == ST_RDWAIT);
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_config_r     <= 16'h0000;
      uart_baudgen_r    <= 16'h0000;
      uart_data_write_r <= 16'h0000;
      uart_write_r      <= 1'b0;
      uart_read_r       <= 1'b0;
      uart_en_r         <= 1'b0;
      configured_r      <= 1'b0;
      rr_last_r         <= RR_RX;
      lat_cnt_r         <= 2'd0;
      m_rx_data_r       <= 16'h0000;
      m_rx_valid_r      <= 1'b0;
    end else begin
      uart_config_r     <= uart_config_s;
      uart_baudgen_r    <= uart_baudgen_s;
      uart_data_write_r <= uart_data_write_s;
      uart_write_r      <= uart_write_s;
      uart_read_r       <= uart_read_s;
      uart_en_r         <= uart_en_s;
      configured_r      <= configured_s;
      rr_last_r         <= rr_last_s;
      lat_cnt_r         <= lat_cnt_s;
      m_rx_data_r       <= m_rx_data_s;
      m_rx_valid_r      <= m_rx_valid_s;
    end
  end

  assign s_tx_ready      = grant_tx_s;
  assign uart_config     = uart_config_r;
  assign uart_baudgen    = uart_baudgen_r;
  assign uart_data_write = uart_data_write_r;
  assign uart_write      = uart_write_r;
  assign uart_read       = uart_read_r;
  assign uart_en         = uart_en_r;
  assign configured      = configured_r;
  assign m_rx_data       = m_rx_data_r;
  assign m_rx_valid      = m_rx_valid_r;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Randomized bench for uart_host_bridge against a transaction-level reference model
// that tracks "powered / settling / busy-for-N-cycles" rather than FSM states.
module tb_uart_host_bridge;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start;
  logic [15:0] cfg_value, baud_value;
  logic [7:0]  s_tx_data;
  logic        s_tx_valid, s_tx_ready;
  logic [15:0] m_rx_data;
  logic        m_rx_valid, m_rx_ready;
  logic [15:0] uart_status, uart_data_read;
  logic [15:0] uart_config, uart_baudgen, uart_data_write;
  logic        uart_write, uart_read, uart_en, configured;

  int n_tests = 0;
  int n_fail  = 0;

  uart_host_bridge #(.TXFULL_BIT(1), .RXEMPTY_BIT(4), .READ_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_value(cfg_value),
    .baud_value(baud_value), .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid),
    .s_tx_ready(s_tx_ready), .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
    .m_rx_ready(m_rx_ready), .uart_status(uart_status), .uart_data_read(uart_data_read),
    .uart_config(uart_config), .uart_baudgen(uart_baudgen), .uart_data_write(uart_data_write),
    .uart_write(uart_write), .uart_read(uart_read), .uart_en(uart_en), .configured(configured)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          powered, cfg_wait, rd_pending, last_was_rx;
  int          busy;
  logic [15:0] exp_cfg, exp_baud, exp_dwr, exp_rdata;
  bit          exp_write, exp_read, exp_rvalid;
  int          n_tx_grants, n_rx_grants;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    powered = 1'b0; cfg_wait = 1'b0; rd_pending = 1'b0; last_was_rx = 1'b1; busy = 0;
    exp_cfg = 16'h0000; exp_baud = 16'h0000; exp_dwr = 16'h0000; exp_rdata = 16'h0000;
    exp_write = 1'b0; exp_read = 1'b0; exp_rvalid = 1'b0;
  endtask

  function automatic bit tx_eligible();
    return s_tx_valid && !uart_status[1];
  endfunction

  function automatic bit rx_eligible();
    return !uart_status[4] && !exp_rvalid;
  endfunction

  function automatic bit accepting();
    return powered && !cfg_wait && busy == 0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_update();
    bit tx_ok, rx_ok, pick_tx;
    tx_ok = tx_eligible();
    rx_ok = rx_eligible();
    pick_tx = tx_ok && (!rx_ok || last_was_rx);
    exp_write = 1'b0;
    exp_read  = 1'b0;
    if (exp_rvalid && m_rx_ready) exp_rvalid = 1'b0;
    if (!powered) begin
      if (cfg_start) begin
        powered = 1'b1; cfg_wait = 1'b1; exp_cfg = cfg_value; exp_baud = baud_value;
      end
    end else if (cfg_wait) begin
      cfg_wait = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0 && rd_pending) begin
        rd_pending = 1'b0; exp_rvalid = 1'b1; exp_rdata = uart_data_read;
      end
    end else if (cfg_start) begin
      cfg_wait = 1'b1; exp_cfg = cfg_value; exp_baud = baud_value;
    end else if (pick_tx) begin
      exp_write = 1'b1; exp_dwr = {8'h00, s_tx_data}; last_was_rx = 1'b0; busy = 1;
      n_tx_grants++;
    end else if (rx_ok) begin
      exp_read = 1'b1; last_was_rx = 1'b1; busy = 1 + LAT; rd_pending = 1'b1;
      n_rx_grants++;
    end
  endtask

  task automatic compare_all();
    bit exp_ready;
    exp_ready = accepting() && !cfg_start && tx_eligible() && (!rx_eligible() || last_was_rx);
    check_eq("s_tx_ready", s_tx_ready, exp_ready);
    check_eq("uart_write", uart_write, exp_write);
    check_eq("uart_read", uart_read, exp_read);
    check_eq("wr_rd_excl", uart_write & uart_read, 1'b0);
    check_eq("uart_data_write", uart_data_write, exp_dwr);
    check_eq("uart_config", uart_config, exp_cfg);
    check_eq("uart_baudgen", uart_baudgen, exp_baud);
    check_eq("uart_en", uart_en, powered && !cfg_wait);
    check_eq("configured", configured, powered && !cfg_wait);
    check_eq("m_rx_valid", m_rx_valid, exp_rvalid);
    check_eq("m_rx_data", m_rx_data, exp_rdata);
  endtask

  task automatic randomize_inputs();
    cfg_start      = ($urandom_range(0, 39) == 0);
    cfg_value      = 16'($urandom);
    baud_value     = 16'($urandom);
    s_tx_data      = 8'($urandom);
    s_tx_valid     = ($urandom_range(0, 3) != 0);
    m_rx_ready     = ($urandom_range(0, 1) == 1);
    uart_status    = 16'($urandom);
    uart_status[1] = ($urandom_range(0, 3) == 0);
    uart_status[4] = ($urandom_range(0, 1) == 1);
    uart_data_read = 16'($urandom);
  endtask

  task automatic tick(input bit rnd);
    @(posedge clk);
    model_update();
    #1;
    if (rnd) randomize_inputs();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    bit found;
    reset = 1'b0; cfg_start = 1'b0; cfg_value = 16'h0000; baud_value = 16'h0000;
    s_tx_data = 8'h00; s_tx_valid = 1'b0; m_rx_ready = 1'b0;
    uart_status = 16'h0010; uart_data_read = 16'h0000;
    n_tx_grants = 0; n_rx_grants = 0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    tick(1'b0);
    tick(1'b0);

    // Configuration
    cfg_start = 1'b1; cfg_value = 16'h0023; baud_value = 16'd325;
    tick(1'b0);
    cfg_start = 1'b0;
    check_eq("cfg_latched", uart_config, 16'h0023);
    check_eq("baud_latched", uart_baudgen, 16'd325);
    tick(1'b0);
    check_eq("en_after_cfg", uart_en, 1'b1);
    tick(1'b0);

    // TX of 0xA5, then TXFULL back-pressure and release
    s_tx_valid = 1'b1; s_tx_data = 8'hA5; uart_status = 16'h0010;
    for (int i = 0; i < 4; i++) tick(1'b0);
    uart_status = 16'h0012;
    for (int i = 0; i < 4; i++) tick(1'b0);
    uart_status = 16'h0010;
    for (int i = 0; i < 3; i++) tick(1'b0);
    s_tx_valid = 1'b0;
    tick(1'b0);

    // RX of 0x0342, held while the client stalls, then released
    uart_status = 16'h0000; uart_data_read = 16'h0342; m_rx_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b0);
    check_eq("rx_held_data", m_rx_data, 16'h0342);
    m_rx_ready = 1'b1;
    tick(1'b0);
    uart_status = 16'h0010;

    // Both sides eligible: alternation
    s_tx_valid = 1'b1; uart_status = 16'h0000; m_rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick(1'b0);
    s_tx_valid = 1'b0; uart_status = 16'h0010;
    tick(1'b0);

    for (int i = 0; i < 3000; i++) tick(1'b1);
    check_eq("tx_grants_seen", n_tx_grants > 50, 1'b1);
    check_eq("rx_grants_seen", n_rx_grants > 50, 1'b1);

    // Reset in the middle of a read access
    cfg_start = 1'b0; s_tx_valid = 1'b0; m_rx_ready = 1'b1; uart_status = 16'h0000;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b0);
      if (uart_read) found = 1'b1;
    end
    check_eq("rdwait_reached", found, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_host_bridge.md
Name: uart_host_bridge

Overview:
- Host-side initiator for the UART peripheral's register interface: programs config/baud, enables the core, then moves bytes between two valid/ready streams and the core's TX/RX FIFOs.
- Drives uart_config, uart_baudgen, uart_data_write, uart_write, uart_read and uart_en.
- Consumes uart_status and uart_data_read.
- Sits between a byte-stream client (DMA/packet engine) and the UART top level, replacing direct CPU register access.

Parameters:
- TXFULL_BIT, 1, index of TX-FIFO-full flag in uart_status.
- RXEMPTY_BIT, 4, index of RX-FIFO-empty flag in uart_status.
- READ_LAT, 1, cycles from uart_read pulse to valid uart_data_read (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle request to (re)configure.
- cfg_value  in  16  value for uart_config.
- baud_value  in  16  value for uart_baudgen.
- s_tx_data  in  8  byte to transmit.
- s_tx_valid  in  1  s_tx_data valid.
- s_tx_ready  out  1  bridge accepts s_tx_data this cycle.
- m_rx_data  out  16  raw uart_data_read word (data plus RX flags).
- m_rx_valid  out  1  m_rx_data valid.
- m_rx_ready  in  1  client accepts m_rx_data.
- uart_status  in  16  core status.
- uart_data_read  in  16  core read data.
- uart_config  out  16  core config register.
- uart_baudgen  out  16  core baud divisor.
- uart_data_write  out  16  core write data, {8'h00, byte}.
- uart_write  out  1  one-cycle TX FIFO push.
- uart_read  out  1  one-cycle RX FIFO pop.
- uart_en  out  1  core enable.
- configured  out  1  high in RUN/GAP/RDWAIT.

Behaviour:
- Reset (reset=0, async) values:
  - All outputs 0, state OFF, m_rx_valid=0, rr_last=RX.
  - uart_config, uart_baudgen and uart_data_write are all 16'h0000.
- States: OFF, CFG, RUN, GAP, RDWAIT.
- OFF: uart_en=0. cfg_start=1 -> latch cfg_value/baud_value into uart_config/uart_baudgen; next state CFG.
- CFG: one settling cycle with uart_en=0, then uart_en=1 (registered); next state RUN.
- RUN, cfg_start=1:
  - Takes precedence over all traffic.
  - Deassert uart_en, latch new values, go to CFG.
  - m_rx_data/m_rx_valid are held; s_tx_ready=0 that cycle.
- cfg_start in CFG/GAP/RDWAIT: ignored.
- Eligibility in RUN:
  - tx_ok = s_tx_valid & ~uart_status[TXFULL_BIT].
  - rx_ok = ~uart_status[RXEMPTY_BIT] & ~m_rx_valid.
- Arbitration in RUN:
  - Only one of tx_ok/rx_ok -> grant it.
  - Both -> grant the side not equal to rr_last.
  - Update rr_last to the granted side.
- s_tx_ready (combinational): high only in RUN, when cfg_start=0 and TX is granted.
- TX grant: on the handshake edge, register uart_write=1 and uart_data_write={8'h00,s_tx_data} for exactly one cycle; go to GAP.
- GAP: one idle cycle so FIFO status reflects the access; then RUN.
- RX grant:
  - Register uart_read=1 for one cycle; go to RDWAIT.
  - Counter counts READ_LAT cycles after the uart_read pulse cycle.
  - At terminal count, capture uart_data_read into m_rx_data and set m_rx_valid=1; go to RUN.
- m_rx_valid: holds data stable until m_rx_valid & m_rx_ready; clears on that edge. Independent of state, so TX proceeds while RX is held.
- Throughput: at most one core access per 2 cycles (TX); RX access costs 2+READ_LAT cycles.
- Never asserts uart_write and uart_read in the same cycle.
- Never writes when TXFULL is set or reads when RXEMPTY is set, as sampled in the grant cycle.
- Reset mid-access: pulses are abandoned and all outputs clear immediately; the pending captured byte is lost.

Test Plan:
- Reset, then cfg_start with cfg_value=16'h0023, baud_value=16'd325:
  - uart_config=16'h0023 and uart_baudgen=325 one cycle later; uart_en=0 during CFG.
  - uart_en=1 and configured=1 two cycles after cfg_start.
- RUN, s_tx_valid=1, data 8'hA5, TXFULL=0:
  - s_tx_ready=1 one cycle; next cycle uart_write=1 with uart_data_write=16'h00A5.
  - Next TX handshake no earlier than 2 cycles later.
- TXFULL=1 with s_tx_valid=1: s_tx_ready stays 0 and no uart_write; deassert TXFULL -> byte written within 2 cycles.
- RXEMPTY=0, READ_LAT=1, uart_data_read=16'h0342:
  - uart_read pulses once; m_rx_valid=1 with m_rx_data=16'h0342 two cycles after the grant.
  - With m_rx_ready=0, no further uart_read while held.
- TX and RX both eligible for 4 consecutive grants: grants alternate TX/RX starting with TX after reset (rr_last=RX); uart_write and uart_read never both high in a cycle.
- Reset asserted during RDWAIT: all outputs 0 asynchronously; after release, state OFF, uart_en=0, m_rx_valid=0.
